// File: rtl/uart_rx_ctrl_if.sv
// Receive controller bundle: receiver-side frame inputs, host read handshake and status outputs.
// master = the side that drives receiver frames and host pops (receiver/host or a bench).
// slave  = uart_rx_ctrl itself; it drives the read data and all status flags.
interface uart_rx_ctrl_if #(
  parameter int AW = 4
);
  // receiver side
  logic          tick;
  logic          rx_done;
  logic [7:0]    rx_data;
  logic          parity_error;
  // host side
  logic          rd_en;
  logic          clr_ovr;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic          rd_valid;
  // status
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          overrun;
  logic          rts_n;
  logic          irq;

  modport master (
    output tick, rx_done, rx_data, parity_error, rd_en, clr_ovr,
    input  rd_data, rd_perr, rd_valid, level, empty, full, overrun, rts_n, irq
  );

  modport slave (
    input  tick, rx_done, rx_data, parity_error, rd_en, clr_ovr,
    output rd_data, rd_perr, rd_valid, level, empty, full, overrun, rts_n, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers {parity_error, rx_data} frames in a 2**AW FIFO and serves
// them to the host with a registered one-cycle read pulse (rd_valid one cycle after rd_en).
// Ports: clk, rst_n (async, active-low), bus (uart_rx_ctrl_if.slave: frames in, reads, status).
// Status: level/empty/full, sticky overrun (frame dropped when full), rts_n with RTS_HI/RTS_LO
// hysteresis, registered irq = level >= IRQ_LVL | overrun | idle timeout.
// Optional macro UART_RX_TIMEOUT_EN adds the idle-timeout counter (TO_TICKS tick pulses).
module uart_rx_ctrl #(
  parameter int AW       = 4,
  parameter int RTS_HI   = 12,
  parameter int RTS_LO   = 4,
  parameter int IRQ_LVL  = 8,
  parameter int TO_TICKS = 640
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_ctrl_if.slave  bus
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW:0] RTS_HI_L  = (AW+1)'(RTS_HI);
  localparam logic [AW:0] RTS_LO_L  = (AW+1)'(RTS_LO);
  localparam logic [AW:0] IRQ_LVL_L = (AW+1)'(IRQ_LVL);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic [7:0]    rd_data;
  logic          rd_perr, rd_valid, overrun, rts_n, irq, to_flag;
  logic          empty, full, pop, push, drop;

  assign empty = (level == '0);
  assign full  = (level == DEPTH_L);
  assign pop   = bus.rd_en & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the frame.
  assign push  = bus.rx_done & (~full | pop);
  assign drop  = bus.rx_done & ~push;

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {bus.parity_error, bus.rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_perr  <= 1'b0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
      rts_n    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr               <= rptr + 1'b1;
        {rd_perr, rd_data} <= mem[rptr];
      end
      rd_valid <= pop;

      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      // A new drop wins over a simultaneous clear.
      if (drop)             overrun <= 1'b1;
      else if (bus.clr_ovr) overrun <= 1'b0;

      // Hysteresis on the registered level; between the watermarks rts_n holds.
      if (level >= RTS_HI_L)      rts_n <= 1'b1;
      else if (level <= RTS_LO_L) rts_n <= 1'b0;

      irq <= (level >= IRQ_LVL_L) | overrun | to_flag;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  // Counts idle tick pulses while data sits unread; any activity or an empty FIFO restarts it.
  logic [9:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (push || pop || empty) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (bus.tick && to_cnt != 10'h3FF) to_cnt <= to_cnt + 1'b1;
      if (to_cnt == 10'(TO_TICKS))       to_flag <= 1'b1;
    end
  end
`else
  logic unused_to;
  assign to_flag   = 1'b0;
  assign unused_to = ^{bus.tick, 10'(TO_TICKS)};
`endif

  assign bus.level    = level;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.rd_data  = rd_data;
  assign bus.rd_perr  = rd_perr;
  assign bus.rd_valid = rd_valid;
  assign bus.overrun  = overrun;
  assign bus.rts_n    = rts_n;
  assign bus.irq      = irq;
endmodule
